// File: rtl/sm2_naf_pkg.sv
// ---------------------------------------------------------------------------
// sm2_naf_pkg
// Shared constants for the NAF encoder and its consumer pointmul_naf:
//   NAF digit codes, default widths and the encoder state encoding.
// ---------------------------------------------------------------------------
package sm2_naf_pkg;

  localparam int NAF_KW = 256;   // scalar width
  localparam int NAF_HW = 1024;  // packed digit vector width (2 bits/digit)
  localparam int NAF_LW = 32;    // hlength width

  // Signed digit codes; 2'b10 is never produced.
  localparam logic [1:0] NAF_ZERO = 2'b00;
  localparam logic [1:0] NAF_POS  = 2'b01;
  localparam logic [1:0] NAF_NEG  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } naf_state_t;

endpackage

// File: rtl/naf_digit.sv
// ---------------------------------------------------------------------------
// naf_digit
// Combinational single-step NAF digit extraction.
// Ports:
//   i_kreg  [KW:0]  remaining scalar value
//   o_digit [1:0]   digit for the current position (NAF_ZERO/POS/NEG)
//   o_knext [KW:0]  remaining value after consuming this digit
// ---------------------------------------------------------------------------
module naf_digit
  import sm2_naf_pkg::*;
#(
  parameter int KW = NAF_KW
) (
  input  logic [KW:0] i_kreg,
  output logic [1:0]  o_digit,
  output logic [KW:0] o_knext
);

  always_comb begin
    o_digit = NAF_ZERO;
    o_knext = {1'b0, i_kreg[KW:1]};
    if (i_kreg[0]) begin
      if (i_kreg[1]) begin
        // Odd value: (k+1)>>1 equals (k>>1)+1, which avoids a KW+2 bit adder.
        o_digit = NAF_NEG;
        o_knext = {1'b0, i_kreg[KW:1]} + {{KW{1'b0}}, 1'b1};
      end else begin
        o_digit = NAF_POS;
      end
    end
  end

endmodule

// File: rtl/naf_encoder.sv
// ---------------------------------------------------------------------------
// naf_encoder
// Converts a binary scalar k into non-adjacent form, one digit per clock.
// Ports:
//   clk      clock
//   rstn     synchronous reset, active-high (1 = reset)
//   k        scalar, sampled when start is accepted
//   start    single-cycle request pulse (ignored while busy)
//   h        packed NAF digits, digit i at h[2i+1:2i]
//   hlength  number of valid digits (0 for k = 0)
//   done     one-cycle pulse when h/hlength are valid
//   busy     high while encoding
// ---------------------------------------------------------------------------
module naf_encoder
  import sm2_naf_pkg::*;
#(
  parameter int KW = NAF_KW,
  parameter int HW = NAF_HW,
  parameter int LW = NAF_LW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [KW-1:0] k,
  input  logic          start,
  output logic [HW-1:0] h,
  output logic [LW-1:0] hlength,
  output logic          done,
  output logic          busy
);

  // Digit counter must reach KW+1.
  localparam int CW = $clog2(KW + 2);
  localparam int IW = $clog2(HW);

  naf_state_t    r_state, w_state_next;
  logic [KW:0]   r_kreg, w_kreg_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [HW-1:0] r_h, w_h_next;
  logic [LW-1:0] r_hlength, w_hlength_next;
  logic          r_done, w_done_next;
  logic          r_busy, w_busy_next;

  logic [1:0]    w_digit;
  logic [KW:0]   w_knext;
  logic [IW-1:0] w_pos;

  naf_digit #(.KW(KW)) u_digit (
    .i_kreg  (r_kreg),
    .o_digit (w_digit),
    .o_knext (w_knext)
  );

  // Bit offset of the digit slot being written this cycle.
  assign w_pos = IW'({r_cnt, 1'b0});

  always_comb begin
    w_state_next   = r_state;
    w_kreg_next    = r_kreg;
    w_cnt_next     = r_cnt;
    w_h_next       = r_h;
    w_hlength_next = r_hlength;
    w_done_next    = 1'b0;
    w_busy_next    = r_busy;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_kreg_next  = {1'b0, k};
          w_h_next     = '0;
          w_cnt_next   = '0;
          w_busy_next  = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_kreg == '0) begin
          // The last emitted digit is always +1, so cnt is the NAF length.
          w_hlength_next = LW'(r_cnt);
          w_done_next    = 1'b1;
          w_busy_next    = 1'b0;
          w_state_next   = IDLE;
        end else begin
          w_h_next[w_pos +: 2] = w_digit;
          w_kreg_next          = w_knext;
          w_cnt_next           = r_cnt + CW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_kreg    <= '0;
      r_cnt     <= '0;
      r_h       <= '0;
      r_hlength <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_kreg    <= w_kreg_next;
      r_cnt     <= w_cnt_next;
      r_h       <= w_h_next;
      r_hlength <= w_hlength_next;
      r_done    <= w_done_next;
      r_busy    <= w_busy_next;
    end
  end

  assign h       = r_h;
  assign hlength = r_hlength;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule

// File: tb/tb_naf_encoder.sv
module tb_naf_encoder;
  import sm2_naf_pkg::*;

  localparam int KW    = NAF_KW;
  localparam int HW    = NAF_HW;
  localparam int LW    = NAF_LW;
  localparam int NRAND = 200;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [KW-1:0] k;
  logic [HW-1:0] h;
  logic [LW-1:0] hlength;
  logic          done;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  always #5 clk = ~clk;

  naf_encoder #(.KW(KW), .HW(HW), .LW(LW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .k       (k),
    .start   (start),
    .h       (h),
    .hlength (hlength),
    .done    (done),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook NAF: for odd v pick d = 2 - (v mod 4), subtract it, halve.
  function automatic void naf_model(input logic [KW-1:0] kin,
                                    output logic [HW-1:0] eh, output int elen);
    logic [KW+1:0] v;
    int i;
    v    = {2'b00, kin};
    eh   = '0;
    elen = 0;
    i    = 0;
    while (v != 0) begin
      if (v[0]) begin
        if (v % 4 == 1) begin
          eh[2*i +: 2] = 2'b01;
          v = v - 1;
        end else begin
          eh[2*i +: 2] = 2'b11;
          v = v + 1;
        end
        elen = i + 1;
      end
      v = v >> 1;
      i++;
    end
  endfunction

  task automatic run_enc(input logic [KW-1:0] kin, input string tag);
    logic [HW-1:0] eh;
    int            elen;
    int            n;
    int            adj;
    int            bad;
    logic [LW-1:0] prev_len;
    logic [KW+1:0] acc;
    logic [1:0]    d;
    naf_model(kin, eh, elen);
    prev_len = hlength;
    @(negedge clk);
    k     = kin;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k     = ~kin;  // k must only matter on the accepting edge
    chk({tag, " busy_run"}, HW'(busy), HW'(1));
    chk({tag, " h_cleared"}, h, '0);
    chk({tag, " hlength_held"}, HW'(hlength), HW'(prev_len));
    n = 0;
    while (n < KW + 8 && done !== 1'b1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, " done_seen"}, HW'(done), HW'(1));
    chk({tag, " latency"}, HW'(n), HW'(elen + 1));
    chk({tag, " h"}, h, eh);
    chk({tag, " hlength"}, HW'(hlength), HW'(elen));
    acc = '0;
    adj = 0;
    bad = 0;
    for (int i = KW; i >= 0; i--) begin
      d   = h[2*i +: 2];
      acc = acc << 1;
      if (d == 2'b01) acc = acc + 1;
      if (d == 2'b11) acc = acc - 1;
      if (d == 2'b10) bad++;
      if (i < KW && d != 2'b00 && h[2*i+2 +: 2] != 2'b00) adj++;
    end
    chk({tag, " reconstruct"}, HW'(acc), HW'(kin));
    chk({tag, " adjacent_nz"}, HW'(adj), '0);
    chk({tag, " code_10"}, HW'(bad), '0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, HW'(done), '0);
    chk({tag, " busy_idle"}, HW'(busy), '0);
    chk({tag, " h_held"}, h, eh);
    txn++;
    $display("txn %0d %s k=%0h hlength=%0d cycles=%0d", txn, tag, kin, hlength, n);
  endtask

  logic [HW-1:0] exp_h;
  logic [KW-1:0] kr;

  initial begin
    rstn  = 1'b1;
    start = 1'b0;
    k     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    chk("reset h", h, '0);
    chk("reset hlength", HW'(hlength), '0);
    chk("reset done", HW'(done), '0);
    chk("reset busy", HW'(busy), '0);

    // Test 1: k=6
    run_enc(KW'(6), "k6");
    chk("k6 h_literal", h, HW'(8'b01001100));
    chk("k6 hlength_literal", HW'(hlength), HW'(4));

    // Test 2: k=0 then k=1
    run_enc('0, "k0");
    chk("k0 h_literal", h, '0);
    run_enc(KW'(1), "k1");
    chk("k1 h_literal", h, HW'(2'b01));

    // Test 3: k=7
    run_enc(KW'(7), "k7");
    chk("k7 h_literal", h, HW'(8'b01000011));

    // Test 4: all ones
    run_enc('1, "kmax");
    exp_h = '0;
    exp_h[1:0]     = 2'b11;
    exp_h[513:512] = 2'b01;
    chk("kmax h_literal", h, exp_h);
    chk("kmax hlength_literal", HW'(hlength), HW'(257));

    // Test 5: start while busy ignored, reset mid-run aborts
    @(negedge clk);
    k     = KW'(6);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    k     = KW'(7);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rstn  = 1'b1;
    chk("abort busy_before_reset", HW'(busy), HW'(1));
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    chk("abort h", h, '0);
    chk("abort hlength", HW'(hlength), '0);
    chk("abort done", HW'(done), '0);
    chk("abort busy", HW'(busy), '0);
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("abort no_done", HW'(seen), '0);
    end
    run_enc(KW'(6), "k6_restart");
    chk("k6_restart h_literal", h, HW'(8'b01001100));

    // Test 6: SM2 n-1 and random scalars
    run_enc(256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54122, "sm2_n_minus_1");
    for (int r = 0; r < NRAND; r++) begin
      for (int w = 0; w < KW / 32; w++) kr[32*w +: 32] = $urandom;
      if (r % 4 == 3) kr = kr >> $urandom_range(0, KW - 1);
      run_enc(kr, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
